instr_fetch_unit: RTL

- Instruction store and fetch stage sitting directly upstream of the microprocessor core. It is loaded byte-by-byte over a valid/ready program port, then serves the core's 8-bit `instr` for the core's `pc`.
- Replaces the bench-driven `instr` input. Guarded program length, registered read, and a load/run state machine keep the core fed with fill words outside the loaded program.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Program-load and fetch signal bundle for instr_fetch_unit.
// slave: the fetch unit's view; master: loader/core side.
interface instr_fetch_unit_if #(
  parameter int AW = 5
);
  logic          load_start;
  logic          load_valid;
  logic [7:0]    load_data;
  logic          load_ready;
  logic          load_done;
  logic [7:0]    pc;
  logic [7:0]    instr;
  logic [AW:0]   prog_len;
  logic          running;
  logic          pc_oob;
  logic          overflow;
  logic [7:0]    checksum;

  modport slave (
    input  load_start, load_valid, load_data, load_done, pc,
    output load_ready, instr, prog_len, running, pc_oob, overflow, checksum
  );

  modport master (
    output load_start, load_valid, load_data, load_done, pc,
    input  load_ready, instr, prog_len, running, pc_oob, overflow, checksum
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Byte-loaded instruction store feeding the core: IDLE/LOAD/RUN, registered fetch.
// Define IFU_CHECKSUM_EN to enable the modulo-256 checksum of loaded bytes.
module instr_fetch_unit #(
  parameter int          DEPTH     = 32,
  parameter int          AW        = 5,
  parameter logic [7:0]  FILL_WORD = 8'h00
) (
  input  logic                clk_50m,
  input  logic                reset,
  instr_fetch_unit_if.slave   bus
);

  localparam int CW = (AW + 1 > 8) ? AW + 1 : 8;
  localparam logic [AW:0] LEN_MAX = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     prog_len_q, prog_len_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      instr_q, instr_d;
  logic            pc_oob_q, pc_oob_d;
  logic            load_ready;
  logic            accept;
  logic [CW-1:0]   pc_ext, len_ext;
  logic [7:0]      mem_q [DEPTH];

  assign pc_ext  = CW'(bus.pc);
  assign len_ext = CW'(prog_len_q);

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      overflow_q <= 1'b0;
      instr_q    <= FILL_WORD;
      pc_oob_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      overflow_q <= overflow_d;
      instr_q    <= instr_d;
      pc_oob_q   <= pc_oob_d;
    end
  end

  // Storage is deliberately not reset; reads beyond prog_len are masked to FILL_WORD.
  always_ff @(posedge clk_50m) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= bus.load_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    overflow_d = overflow_q;
    instr_d    = FILL_WORD;
    pc_oob_d   = 1'b0;
    load_ready = 1'b0;
    accept     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.load_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_ready = (prog_len_q < LEN_MAX);
        // A restart pulse drops any beat offered alongside it.
        if (!bus.load_start) begin
          if (bus.load_valid && load_ready) begin
            accept     = 1'b1;
            prog_len_d = prog_len_q + (AW + 1)'(1);
            if (wr_ptr_q != AW'(DEPTH - 1)) wr_ptr_d = wr_ptr_q + AW'(1);
          end else if (bus.load_valid) begin
            overflow_d = 1'b1;
          end
          if (bus.load_done) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.load_start) begin
          state_d = S_LOAD;
        end else begin
          pc_oob_d = (pc_ext >= len_ext);
          instr_d  = (pc_ext < len_ext) ? mem_q[bus.pc[AW-1:0]] : FILL_WORD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.load_start) begin
      state_d    = S_LOAD;
      wr_ptr_d   = '0;
      prog_len_d = '0;
      overflow_d = 1'b0;
    end
  end

`ifdef IFU_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (bus.load_start) checksum_d = '0;
    else if (accept)    checksum_d = checksum_q + bus.load_data;
  end

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif

  assign bus.load_ready = load_ready;
  assign bus.instr      = instr_q;
  assign bus.prog_len   = prog_len_q;
  assign bus.running    = (state_q == S_RUN);
  assign bus.pc_oob     = pc_oob_q;
  assign bus.overflow   = overflow_q;

endmodule
